// File: rtl/music_playback_sequencer_if.sv
// Control, ROM and tone-generator signals of the playback sequencer.
// master = sequencer side, slave = selector/ROM/tone-generator side.
interface music_playback_sequencer_if #(
    parameter int IDX_W  = 6,
    parameter int NOTE_W = 5
);
    logic [1:0]        track_sel;
    logic              start;
    logic              play_pause;
    logic              stop;
    logic [IDX_W+1:0]  rom_addr;
    logic [NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic              busy;
    logic              track_done;
    logic              next_req;

    modport master (
        input  track_sel, start, play_pause, stop, rom_data,
        output rom_addr, note_out, note_valid, busy, track_done, next_req
    );

    modport slave (
        output track_sel, start, play_pause, stop, rom_data,
        input  rom_addr, note_out, note_valid, busy, track_done, next_req
    );
endinterface

// File: rtl/music_playback_sequencer.sv
// Note playback sequencer: fetch, hold, pause/resume, stop, end-of-track.
// Optional AUTO_NEXT_EN: pulse next_req together with track_done.
module music_playback_sequencer #(
    parameter int IDX_W          = 6,
    parameter int NOTE_W         = 5,
    parameter int END_CODE       = 31,
    parameter int TICKS_PER_NOTE = 4
) (
    input logic                      clk,
    input logic                      reset,
    music_playback_sequencer_if.master bus
);
    localparam int TW = (TICKS_PER_NOTE > 2) ? $clog2(TICKS_PER_NOTE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_NOTE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        PAUSED
    } state_t;

    state_t            state;
    logic [1:0]        track;
    logic [IDX_W-1:0]  idx;
    logic [TW-1:0]     tick;
    logic              pend;
    logic [IDX_W+1:0]  rom_addr_q;
    logic [NOTE_W-1:0] note_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic [IDX_W-1:0]  idx_nxt;
    logic              note_end;
    logic              resume_adv;
    logic              advance;
    logic              end_code;
    logic              track_end;

    assign idx_nxt    = idx + 1'b1;
    assign note_end   = (state == PLAY) && (tick == TICK_LAST) && !bus.play_pause;
    // a pause landing on the last tick is remembered so resume moves straight on
    assign resume_adv = (state == PAUSED) && bus.play_pause && pend;
    assign advance    = note_end || resume_adv;
    assign end_code   = (state == WAIT) && (bus.rom_data == NOTE_W'(END_CODE));
    assign track_end  = end_code || (advance && (&idx));

`ifdef AUTO_NEXT_EN
    logic next_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            track      <= '0;
            idx        <= '0;
            tick       <= '0;
            pend       <= 1'b0;
            rom_addr_q <= '0;
            note_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef AUTO_NEXT_EN
            next_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef AUTO_NEXT_EN
            next_q <= 1'b0;
`endif
            if (bus.stop && (state != IDLE)) begin
                state   <= IDLE;
                idx     <= '0;
                tick    <= '0;
                pend    <= 1'b0;
                note_q  <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else if (bus.start && !bus.stop) begin
                state      <= FETCH;
                track      <= bus.track_sel;
                idx        <= '0;
                tick       <= '0;
                pend       <= 1'b0;
                rom_addr_q <= {bus.track_sel, {IDX_W{1'b0}}};
                valid_q    <= 1'b0;
                busy_q     <= 1'b1;
            end else if (track_end) begin
                state   <= IDLE;
                idx     <= '0;
                tick    <= '0;
                pend    <= 1'b0;
                note_q  <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`ifdef AUTO_NEXT_EN
                next_q  <= 1'b1;
`endif
            end else if (advance) begin
                state      <= FETCH;
                idx        <= idx_nxt;
                rom_addr_q <= {track, idx_nxt};
                tick       <= '0;
                pend       <= 1'b0;
                valid_q    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    FETCH: state <= WAIT;
                    WAIT: begin
                        note_q  <= bus.rom_data;
                        tick    <= '0;
                        state   <= PLAY;
                        valid_q <= 1'b1;
                    end
                    PLAY: begin
                        if (bus.play_pause) begin
                            state   <= PAUSED;
                            valid_q <= 1'b0;
                            if (tick == TICK_LAST) pend <= 1'b1;
                            else tick <= tick + 1'b1;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (bus.play_pause) begin
                            state   <= PLAY;
                            valid_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.note_out   = note_q;
    assign bus.note_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.track_done = done_q;
`ifdef AUTO_NEXT_EN
    assign bus.next_req   = next_q;
`else
    assign bus.next_req   = 1'b0;
`endif
endmodule

// File: tb/tb_music_playback_sequencer.sv
// Self-checking bench for music_playback_sequencer: note scoreboard plus
// per-scenario timing checks (reset, play, pause, stop/restart, wrap, auto-next).
module tb_music_playback_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    music_playback_sequencer_if #(.IDX_W(6), .NOTE_W(5)) bus ();

    music_playback_sequencer #(
        .IDX_W(6), .NOTE_W(5), .END_CODE(31), .TICKS_PER_NOTE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [4:0] rom [0:255];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int next_cnt = 0;
    bit resume_pending = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_done = 1'b0;
    logic [4:0] exp_q[$];

    // Scoreboard: each fresh note onset must match the next expected note
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.note_valid && !prev_valid) begin
                if (resume_pending) begin
                    resume_pending = 1'b0;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL note_onset: got note %0d, required none", bus.note_out);
                    end else begin
                        automatic logic [4:0] e = exp_q.pop_front();
                        if (bus.note_out !== e) begin
                            fails++;
                            $display("FAIL note_onset: got %0d, required %0d", bus.note_out, e);
                        end
                    end
                end
            end
            if (bus.track_done) begin
                done_cnt++;
                checks++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_width: track_done high 2 clks, required 1");
                end
            end
            if (bus.next_req) next_cnt++;
        end
        prev_valid = bus.note_valid;
        prev_done = bus.track_done;
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] t);
        bus.track_sel = t;
        bus.start = 1'b1;
        tick_clk();
        bus.start = 1'b0;
    endtask

    task automatic wait_onset(input logic [4:0] n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.note_valid && bus.note_out == n) begin
                ok = 1'b1;
                break;
            end
            tick_clk();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.track_done) begin
                ok = 1'b1;
                break;
            end
            tick_clk();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.track_sel = 2'd1;
        bus.start = 1'b1;
        tick_clk();
        tick_clk();
        checks++;
        if ({bus.rom_addr, bus.note_out, bus.note_valid, bus.busy,
             bus.track_done, bus.next_req} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs: got addr=%0d note=%0d v=%b busy=%b done=%b next=%b, required all 0",
                     bus.rom_addr, bus.note_out, bus.note_valid, bus.busy,
                     bus.track_done, bus.next_req);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        tick_clk();
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_busy: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_play();
        int d0 = done_cnt;
        bit ok;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd12);
        pulse_start(2'd1);
        checks++;
        if (bus.busy !== 1'b1 || bus.rom_addr !== 8'd64 || bus.note_valid !== 1'b0) begin
            fails++;
            $display("FAIL play_fetch: got busy=%b addr=%0d v=%b, required 1 64 0",
                     bus.busy, bus.rom_addr, bus.note_valid);
        end
        tick_clk();
        tick_clk();
        checks++;
        if (bus.note_valid !== 1'b1 || bus.note_out !== 5'd3) begin
            fails++;
            $display("FAIL play_latency: got v=%b note=%0d, required 1 3",
                     bus.note_valid, bus.note_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            checks++;
            if (bus.note_valid !== 1'b1) begin
                fails++;
                $display("FAIL play_hold: cycle %0d got v=%b, required 1", i + 1, bus.note_valid);
            end
        end
        tick_clk();
        checks++;
        if (bus.note_valid !== 1'b0 || bus.note_out !== 5'd3 || bus.rom_addr !== 8'd65) begin
            fails++;
            $display("FAIL play_gap: got v=%b note=%0d addr=%0d, required 0 3 65",
                     bus.note_valid, bus.note_out, bus.rom_addr);
        end
        wait_done(60, ok);
        checks++;
        if (ok !== 1'b1 || bus.busy !== 1'b0 || bus.note_out !== 5'd0) begin
            fails++;
            $display("FAIL play_end: got done=%b busy=%b note=%0d, required 1 0 0",
                     ok, bus.busy, bus.note_out);
        end
        tick_clk();
        checks++;
        if (done_cnt !== d0 + 1 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL play_done_count: got %0d pulses, %0d notes left, required 1 and 0",
                     done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_pause();
        bit ok;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd12);
        pulse_start(2'd1);
        wait_onset(5'd7, 40, ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL pause_reach7: got timeout, required note 7");
        end
        tick_clk();
        bus.play_pause = 1'b1;
        tick_clk();
        bus.play_pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.note_valid !== 1'b0 || bus.note_out !== 5'd7 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL pause_hold: cycle %0d got v=%b note=%0d busy=%b, required 0 7 1",
                         i, bus.note_valid, bus.note_out, bus.busy);
            end
            if (i < 9) tick_clk();
        end
        resume_pending = 1'b1;
        bus.play_pause = 1'b1;
        tick_clk();
        bus.play_pause = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.note_valid !== 1'b1 || bus.note_out !== 5'd7) begin
                fails++;
                $display("FAIL pause_resume: cycle %0d got v=%b note=%0d, required 1 7",
                         i, bus.note_valid, bus.note_out);
            end
            tick_clk();
        end
        checks++;
        if (bus.note_valid !== 1'b0 || bus.rom_addr !== 8'd66) begin
            fails++;
            $display("FAIL pause_next_fetch: got v=%b addr=%0d, required 0 66",
                     bus.note_valid, bus.rom_addr);
        end
        wait_done(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL pause_end: got timeout, required track_done");
        end
        tick_clk();
    endtask

    task automatic test_stop_restart();
        int d0 = done_cnt;
        int n0 = next_cnt;
        bit ok;
        exp_q.push_back(5'd3);
        pulse_start(2'd1);
        wait_onset(5'd3, 10, ok);
        tick_clk();
        bus.stop = 1'b1;
        bus.play_pause = 1'b1;
        tick_clk();
        bus.stop = 1'b0;
        bus.play_pause = 1'b0;
        checks++;
        if (ok !== 1'b1 || bus.busy !== 1'b0 || bus.note_out !== 5'd0 || bus.note_valid !== 1'b0) begin
            fails++;
            $display("FAIL stop_idle: got ok=%b busy=%b note=%0d v=%b, required 1 0 0 0",
                     ok, bus.busy, bus.note_out, bus.note_valid);
        end
        repeat (4) tick_clk();
        checks++;
        if (done_cnt !== d0 || next_cnt !== n0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL stop_no_done: got %0d done %0d next busy=%b, required 0 0 0",
                     done_cnt - d0, next_cnt - n0, bus.busy);
        end
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        pulse_start(2'd1);
        wait_onset(5'd7, 40, ok);
        exp_q.push_back(5'd9);
        exp_q.push_back(5'd10);
        pulse_start(2'd2);
        bus.track_sel = 2'd0;
        checks++;
        if (ok !== 1'b1 || bus.rom_addr !== 8'd128 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_addr: got ok=%b addr=%0d busy=%b, required 1 128 1",
                     ok, bus.rom_addr, bus.busy);
        end
        wait_done(40, ok);
        tick_clk();
        checks++;
        if (ok !== 1'b1 || done_cnt !== d0 + 1 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL restart_end: got ok=%b done=%0d left=%0d, required 1 1 0",
                     ok, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int d0 = done_cnt;
        bit ok = 1'b0;
        bit left0 = 1'b0;
        bit reread = 1'b0;
        for (int i = 0; i < 64; i++) exp_q.push_back(5'(i % 31));
        pulse_start(2'd3);
        for (int i = 0; i < 500; i++) begin
            if (bus.rom_addr != 8'd192) left0 = 1'b1;
            else if (left0) reread = 1'b1;
            if (bus.track_done) begin
                ok = 1'b1;
                break;
            end
            tick_clk();
        end
        checks++;
        if (ok !== 1'b1 || reread !== 1'b0 || bus.rom_addr !== 8'd255 || bus.note_out !== 5'd0) begin
            fails++;
            $display("FAIL wrap_end: got ok=%b reread=%b addr=%0d note=%0d, required 1 0 255 0",
                     ok, reread, bus.rom_addr, bus.note_out);
        end
        repeat (5) tick_clk();
        checks++;
        if (done_cnt !== d0 + 1 || exp_q.size() !== 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL wrap_count: got done=%0d left=%0d busy=%b, required 1 0 0",
                     done_cnt - d0, exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_auto_next();
        bit ok;
        logic exp_next;
`ifdef AUTO_NEXT_EN
        exp_next = 1'b1;
`else
        exp_next = 1'b0;
`endif
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd12);
        pulse_start(2'd1);
        wait_done(60, ok);
        checks++;
        if (ok !== 1'b1 || bus.next_req !== exp_next) begin
            fails++;
            $display("FAIL auto_next: got done=%b next_req=%b, required 1 %b",
                     ok, bus.next_req, exp_next);
        end
        tick_clk();
        checks++;
        if (bus.next_req !== 1'b0 || next_cnt !== (exp_next ? 5 : 0)) begin
            fails++;
            $display("FAIL auto_next_count: got next_req=%b count=%0d, required 0 %0d",
                     bus.next_req, next_cnt, exp_next ? 5 : 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 5'd0;
        rom[64] = 5'd3;
        rom[65] = 5'd7;
        rom[66] = 5'd12;
        rom[67] = 5'd31;
        rom[128] = 5'd9;
        rom[129] = 5'd10;
        rom[130] = 5'd31;
        for (int i = 0; i < 64; i++) rom[192 + i] = 5'(i % 31);
        bus.track_sel = 2'd0;
        bus.start = 1'b0;
        bus.play_pause = 1'b0;
        bus.stop = 1'b0;
        test_reset();
        test_play();
        test_pause();
        test_stop_restart();
        test_wrap();
        test_auto_next();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
